// File: rtl/generic_sram_line_en_target_pkg.sv
// Shared types for the SRAM line-enable target: error codes, FSM states, counter limit.
// Optional out-of-range checking in the top is enabled by GENERIC_SRAM_LINE_EN_TARGET_OOB_CHECK_EN.
package generic_sram_line_en_target_pkg;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_COLLISION = 2'd1,
    ERR_BUSY      = 2'd2,
    ERR_OOB       = 2'd3
  } err_code_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == COUNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/generic_sram_line_en_target_mem.sv
// Single-port synchronous RAM with a one-cycle registered read; the array itself is not reset.
// rdata holds its value until the next read.
module generic_sram_line_en_target_mem #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/generic_sram_line_en_target.sv
// SRAM target for the line-enable master: clears the array after reset, then serves 1-cycle reads/writes,
// latching protocol errors and saturating access counters. GENERIC_SRAM_LINE_EN_TARGET_OOB_CHECK_EN adds range checks.
module generic_sram_line_en_target
  import generic_sram_line_en_target_pkg::*;
#(
  parameter int NUM_ADDR_BITS     = 32,
  parameter int NUM_DATA_BITS     = 32,
  parameter int NUM_MEM_ADDR_BITS = 10,
  parameter int MEM_DEPTH         = 2**NUM_MEM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_ADDR_BITS-1:0] addr,
  input  logic [NUM_DATA_BITS-1:0] write_data,
  input  logic                     write_en,
  input  logic                     read_en,
  output logic [NUM_DATA_BITS-1:0] read_data,
  output logic                     init_done,
  output logic                     err,
  output logic [1:0]               err_code,
  input  logic                     err_clr,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
);

  localparam int AW = NUM_MEM_ADDR_BITS;

  state_e              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                init_done_q, init_done_d;
  logic                err_q, err_d;
  err_code_e           err_code_q, err_code_d;
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic                oob_rd_q, oob_rd_d;

  logic                     mem_we;
  logic                     mem_re;
  logic [AW-1:0]            mem_idx;
  logic [NUM_DATA_BITS-1:0] mem_wdata;
  logic [NUM_DATA_BITS-1:0] mem_rdata;
  logic [AW-1:0]            user_idx;
  logic                     oob;
  err_code_e                new_err;

  assign user_idx = addr[AW-1:0];

`ifdef GENERIC_SRAM_LINE_EN_TARGET_OOB_CHECK_EN
  // A wide compare covers both addr >= MEM_DEPTH and any stray upper bit.
  assign oob = (64'(addr) >= 64'(MEM_DEPTH));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[NUM_ADDR_BITS-1:AW];
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    oob_rd_d    = oob_rd_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_idx     = user_idx;
    mem_wdata   = write_data;
    new_err     = ERR_NONE;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + AW'(1);
        if (ptr_q == AW'(MEM_DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
        if (write_en || read_en) begin
          new_err = ERR_BUSY;
        end
      end
      ST_RUN: begin
        if (write_en && read_en) begin
          new_err = ERR_COLLISION;
        end else if ((write_en || read_en) && oob) begin
          new_err = ERR_OOB;
          if (read_en) begin
            oob_rd_d = 1'b1;
          end
        end else if (write_en) begin
          mem_we   = 1'b1;
          wr_cnt_d = sat_inc(wr_cnt_q);
        end else if (read_en) begin
          mem_re   = 1'b1;
          rd_cnt_d = sat_inc(rd_cnt_q);
          oob_rd_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Clear first so an error in the same cycle as err_clr is the one retained.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
    if (new_err != ERR_NONE) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_code_d = new_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      oob_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      oob_rd_q    <= oob_rd_d;
    end
  end

  generic_sram_line_en_target_mem #(
    .DW (NUM_DATA_BITS),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  assign read_data = oob_rd_q ? '1 : mem_rdata;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule
